// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select arbiter: channel count,
// select width, FSM state encoding and the rotating-pointer reset value.
package mux_sel_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Pointer starts at the last channel so channel 0 wins first after reset.
    localparam logic [SEL_W-1:0] LAST_RST = 2'b11;

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NCH'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder. Search order is
// start+1, start+2, start+3, start (mod NCH).
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = start + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select/enable generator for a 4:1 channel mux.
// Optional dwell limit enabled by defining MUX_SEL_TIMEOUT_EN.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int unsigned DWELL   = 8,
    parameter int unsigned DWELL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    // "release" is a reserved word, so the grantee-finished input is rel.
    input  logic             rel,
    output logic [SEL_W-1:0] se,
    output logic             en,
    output logic [NCH-1:0]   gnt,
    output logic             timeout
);

    if (DWELL == 0 || DWELL > (32'd1 << DWELL_W)) begin : g_dwell_range
        $error("mux_sel_arbiter: DWELL out of range 1..2**DWELL_W");
    end

    state_t           state;
    logic [SEL_W-1:0] last;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic             expire;
    logic             eog;

    // In GRANT last equals se, so one encoder serves both the idle and
    // the end-of-grant arbitration with the current channel lowest.
    rr_pick u_pick (
        .req   (req),
        .start (last),
        .found (found),
        .idx   (pick)
    );

`ifdef MUX_SEL_TIMEOUT_EN
    localparam logic [DWELL_W-1:0] CNT_MAX = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt;

    assign expire = (state == GRANT) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE || eog) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign eog = rel || !req[se] || expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= LAST_RST;
            se      <= '0;
            en      <= 1'b0;
            gnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        last  <= pick;
                        se    <= pick;
                        en    <= 1'b1;
                        gnt   <= onehot(pick);
                    end
                end
                GRANT: begin
                    if (eog) begin
                        // A simultaneous release wins over expiry.
                        timeout <= expire && !rel;
                        if (found) begin
                            last <= pick;
                            se   <= pick;
                            gnt  <= onehot(pick);
                        end else begin
                            state <= IDLE;
                            en    <= 1'b0;
                            gnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
